// File: rtl/sd_init_ctrl.sv
// SD card identification/init sequencer: drives cmd_driver through CMD0, CMD8,
// CMD55/ACMD41 polling, CMD2, CMD3, CMD7 and CMD55/ACMD6. It reports the RCA, the CCS bit and done/error.
module sd_init_ctrl #(
  parameter int unsigned POWERUP_CYC  = 80,
  parameter int unsigned CMD0_WAIT    = 64,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter int unsigned ACMD41_TRIES = 1000
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  output logic        ocmd_start,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  output logic        odrv_rst,
  input  logic [31:0] iresp,
  input  logic        idone,
  output logic [15:0] orca,
  output logic        ohcs,
  output logic        odone,
  output logic        oerror,
  output logic [2:0]  oerr_code
);

  typedef enum logic [3:0] {
    StIdle, StPwrup, StCmd0, StCmd0Wait, StIssue, StWait, StEval, StDone, StError
  } state_e;

  typedef enum logic [2:0] {
    StepCmd8, StepCmd55, StepAcmd41, StepCmd2, StepCmd3, StepCmd7, StepCmd55Bus, StepAcmd6
  } step_e;

  state_e      state_q, state_d;
  step_e       step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tries_q, tries_d;
  logic [31:0] resp_q, resp_d;
  logic [15:0] rca_q, rca_d;
  logic        hcs_q, hcs_d;
  logic [2:0]  code_q, code_d;
  logic        start_q;
  logic        start_edge, timed_out;
  logic [5:0]  step_index;
  logic [31:0] step_arg;
  logic        unused_resp;

  assign start_edge  = istart & ~start_q;
  assign timed_out   = (cnt_q == TIMEOUT_CYC - 1);
  assign unused_resp = ^resp_q[15:12];

  always_comb begin
    step_index = 6'd0;
    step_arg   = 32'h0;
    case (step_q)
      StepCmd8:     begin step_index = 6'd8;  step_arg = 32'h0000_01AA;    end
      StepCmd55:    begin step_index = 6'd55; step_arg = 32'h0;            end
      StepAcmd41:   begin step_index = 6'd41; step_arg = 32'h40FF_8000;    end
      StepCmd2:     begin step_index = 6'd2;  step_arg = 32'h0;            end
      StepCmd3:     begin step_index = 6'd3;  step_arg = 32'h0;            end
      StepCmd7:     begin step_index = 6'd7;  step_arg = {rca_q, 16'h0};   end
      StepCmd55Bus: begin step_index = 6'd55; step_arg = {rca_q, 16'h0};   end
      StepAcmd6:    begin step_index = 6'd6;  step_arg = 32'h0000_0002;    end
      default:      ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    resp_d     = resp_q;
    rca_d      = rca_q;
    hcs_d      = hcs_q;
    code_d     = code_q;
    ocmd_start = 1'b0;
    odrv_rst   = 1'b0;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start_edge) begin
          state_d = StPwrup;
          cnt_d   = 32'd0;
          tries_d = 32'd0;
          code_d  = 3'd0;
        end
      end
      StPwrup: begin
        if (cnt_q == POWERUP_CYC - 1) begin
          state_d = StCmd0;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StCmd0: begin
        ocmd_start = 1'b1;
        cnt_d      = cnt_q + 32'd1;
        if (timed_out) begin
          odrv_rst = 1'b1;
          code_d   = 3'd1;
          state_d  = StError;
        end else if (!idone) begin
          state_d = StCmd0Wait;
        end
      end
      StCmd0Wait: begin
        cnt_d = cnt_q + 32'd1;
        // CMD0 has no response, so the driver sits waiting for one until reset.
        if (cnt_q >= CMD0_WAIT - 1) begin
          odrv_rst = 1'b1;
          state_d  = StIssue;
          step_d   = StepCmd8;
          cnt_d    = 32'd0;
        end
      end
      StIssue, StWait: begin
        ocmd_start = (state_q == StIssue);
        cnt_d      = cnt_q + 32'd1;
        if (timed_out) begin
          odrv_rst = 1'b1;
          code_d   = 3'd1;
          state_d  = StError;
        end else if (state_q == StIssue && !idone) begin
          state_d = StWait;
        end else if (state_q == StWait && idone) begin
          resp_d  = iresp;
          state_d = StEval;
        end
      end
      StEval: begin
        state_d = StIssue;
        cnt_d   = 32'd0;
        case (step_q)
          StepCmd8: begin
            if (resp_q[11:0] != 12'h1AA) begin
              state_d = StError;
              code_d  = 3'd2;
            end else begin
              step_d = StepCmd55;
            end
          end
          StepCmd55: step_d = StepAcmd41;
          StepAcmd41: begin
            if (resp_q[31]) begin
              hcs_d  = resp_q[30];
              step_d = StepCmd2;
            end else begin
              tries_d = tries_q + 32'd1;
              if (tries_d == ACMD41_TRIES) begin
                state_d = StError;
                code_d  = 3'd3;
              end else begin
                step_d = StepCmd55;
              end
            end
          end
          StepCmd2: step_d = StepCmd3;
          StepCmd3: begin
            rca_d  = resp_q[31:16];
            step_d = StepCmd7;
          end
          StepCmd7:     step_d = StepCmd55Bus;
          StepCmd55Bus: step_d = StepAcmd6;
          StepAcmd6:    state_d = StDone;
          default:      state_d = StError;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= StIdle;
      step_q  <= StepCmd8;
      cnt_q   <= 32'd0;
      tries_q <= 32'd0;
      resp_q  <= 32'd0;
      rca_q   <= 16'd0;
      hcs_q   <= 1'b0;
      code_q  <= 3'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      resp_q  <= resp_d;
      rca_q   <= rca_d;
      hcs_q   <= hcs_d;
      code_q  <= code_d;
      start_q <= istart;
    end
  end

  // Command fields are only driven while a command is in flight.
  assign ocmd_index = (state_q == StIssue || state_q == StWait) ? step_index : 6'd0;
  assign ocmd_arg   = (state_q == StIssue || state_q == StWait) ? step_arg : 32'd0;
  assign orca       = rca_q;
  assign ohcs       = hcs_q;
  assign odone      = (state_q == StDone);
  assign oerror     = (state_q == StError);
  assign oerr_code  = code_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: a cmd_driver/card model answers commands. A command-sequence
// model derived from the init rules is compared against the DUT on every cycle.
module tb_sd_init_ctrl;

  localparam int unsigned PWR   = 20;
  localparam int unsigned C0W   = 12;
  localparam int unsigned TMO   = 48;
  localparam int unsigned TRIES = 4;
  localparam logic [15:0] CARD_RCA = 16'hB368;

  logic        iclk = 1'b0;
  logic        irst, istart, ocmd_start, odrv_rst, idone, ohcs, odone, oerror;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg, iresp;
  logic [15:0] orca;
  logic [2:0]  oerr_code;

  int checks = 0;
  int errors = 0;

  sd_init_ctrl #(
    .POWERUP_CYC (PWR),
    .CMD0_WAIT   (C0W),
    .TIMEOUT_CYC (TMO),
    .ACMD41_TRIES(TRIES)
  ) dut (
    .iclk      (iclk),
    .irst      (irst),
    .istart    (istart),
    .ocmd_start(ocmd_start),
    .ocmd_index(ocmd_index),
    .ocmd_arg  (ocmd_arg),
    .odrv_rst  (odrv_rst),
    .iresp     (iresp),
    .idone     (idone),
    .orca      (orca),
    .ohcs      (ohcs),
    .odone     (odone),
    .oerror    (oerror),
    .oerr_code (oerr_code)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Card behaviour knobs
  logic [11:0] cfg_echo;
  int          cfg_ready;   // ACMD41 attempt that reports ready, 0 = never
  logic        cfg_hcs;
  int          cfg_silent;  // command index the card never answers, -1 = none

  // Expected-sequence model
  logic [37:0] exp_q[$];
  logic        exp_done;
  logic [2:0]  exp_code;
  logic [15:0] exp_rca;
  logic        exp_hcs;

  task automatic model_run();
    int n;
    exp_q.delete();
    exp_done = 1'b0;
    exp_code = 3'd0;
    exp_rca  = 16'd0;
    exp_hcs  = 1'b0;
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd8, 32'h0000_01AA});
    if (cfg_echo != 12'h1AA) begin
      exp_code = 3'd2;
      return;
    end
    n = 0;
    while (1) begin
      exp_q.push_back({6'd55, 32'd0});
      exp_q.push_back({6'd41, 32'h40FF_8000});
      n++;
      if (cfg_ready != 0 && n >= cfg_ready) break;
      if (n == int'(TRIES)) begin
        exp_code = 3'd3;
        return;
      end
    end
    exp_q.push_back({6'd2, 32'd0});
    exp_q.push_back({6'd3, 32'd0});
    if (cfg_silent == 3) begin
      exp_code = 3'd1;
      return;
    end
    exp_rca = CARD_RCA;
    exp_hcs = cfg_hcs;
    exp_q.push_back({6'd7, CARD_RCA, 16'h0});
    exp_q.push_back({6'd55, CARD_RCA, 16'h0});
    exp_q.push_back({6'd6, 32'h0000_0002});
    exp_done = 1'b1;
  endtask

  // Driver + card model
  int          drv_lat, card_n41, n41, n55;
  bit          drv_busy;
  logic [5:0]  drv_idx, last_idx;
  logic [31:0] last_arg;

  function automatic logic [31:0] card_resp(input logic [5:0] idx);
    case (idx)
      6'd8:    return {20'd0, cfg_echo};
      6'd55:   return 32'h0000_0120;
      6'd41:   return (cfg_ready != 0 && card_n41 >= cfg_ready) ?
                      {1'b1, cfg_hcs, 30'h00FF_8000} : 32'h00FF_8000;
      6'd3:    return {CARD_RCA, 16'h0000};
      default: return 32'h0000_0900;
    endcase
  endfunction

  initial begin
    idone    = 1'b1;
    iresp    = 32'd0;
    drv_busy = 1'b0;
    drv_lat  = 0;
    drv_idx  = 6'd0;
    card_n41 = 0;
    last_idx = 6'd0;
    last_arg = 32'd0;
    forever begin
      @(negedge iclk);
      if (irst || odrv_rst) begin
        drv_busy = 1'b0;
        idone    = 1'b1;
      end else if (drv_busy) begin
        if (drv_lat > 0) drv_lat--;
        else if (drv_idx != 6'd0 && int'(drv_idx) != cfg_silent) begin
          iresp    = card_resp(drv_idx);
          idone    = 1'b1;
          drv_busy = 1'b0;
        end
      end else if (ocmd_start) begin
        drv_idx  = ocmd_index;
        drv_busy = 1'b1;
        idone    = 1'b0;
        drv_lat  = 3;
        last_idx = ocmd_index;
        last_arg = ocmd_arg;
        if (ocmd_index == 6'd0) card_n41 = 0;
        if (ocmd_index == 6'd41) begin
          card_n41++;
          n41++;
        end
        if (ocmd_index == 6'd55) n55++;
      end
    end
  end

  // Compare process
  bit          chk_en = 1'b0;
  bit          fin_seen = 1'b0;
  bit          prev_start = 1'b0;
  bit          prev_rst = 1'b0;
  logic [37:0] cur_cmd;

  initial begin
    forever begin
      @(posedge iclk);
      #1;
      if (chk_en) begin
        if (ocmd_start && !prev_start) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got index %0d expected no command", ocmd_index);
          end else begin
            cur_cmd = exp_q.pop_front();
            chk("cmd_index", 32'(ocmd_index), 32'(cur_cmd[37:32]));
            chk("cmd_arg", ocmd_arg, cur_cmd[31:0]);
          end
        end
        if (odrv_rst && prev_rst) chk("drv_rst_width", 32'd2, 32'd1);
        if (!fin_seen) begin
          if (odone || oerror) begin
            fin_seen = 1'b1;
            chk("cmds_left", 32'(exp_q.size()), 32'd0);
            chk("done", 32'(odone), 32'(exp_done));
            chk("error", 32'(oerror), 32'(exp_code != 3'd0));
            chk("err_code", 32'(oerr_code), 32'(exp_code));
            if (exp_done) begin
              chk("rca", 32'(orca), 32'(exp_rca));
              chk("hcs", 32'(ohcs), 32'(exp_hcs));
            end
          end else begin
            chk("err_code_running", 32'(oerr_code), 32'd0);
          end
        end else begin
          chk("done_hold", 32'(odone), 32'(exp_done));
          chk("error_hold", 32'(oerror), 32'(exp_code != 3'd0));
          chk("code_hold", 32'(oerr_code), 32'(exp_code));
          chk("start_idle", 32'(ocmd_start), 32'd0);
        end
      end
      prev_start = ocmd_start;
      prev_rst   = odrv_rst;
    end
  end

  task automatic start_run();
    istart = 1'b0;
    @(negedge iclk);
    model_run();
    fin_seen = 1'b0;
    n41      = 0;
    n55      = 0;
    istart   = 1'b1;
    chk_en   = 1'b1;
  endtask

  task automatic wait_fin(input int budget);
    int i;
    i = 0;
    @(negedge iclk);
    while (!(odone || oerror) && i < budget) begin
      @(negedge iclk);
      i++;
    end
    if (!(odone || oerror)) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done/error expected one within %0d cycles", budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"}, 32'(ocmd_start), 32'd0);
    chk({tag, "_index"}, 32'(ocmd_index), 32'd0);
    chk({tag, "_arg"}, ocmd_arg, 32'd0);
    chk({tag, "_drv_rst"}, 32'(odrv_rst), 32'd0);
    chk({tag, "_rca"}, 32'(orca), 32'd0);
    chk({tag, "_hcs"}, 32'(ohcs), 32'd0);
    chk({tag, "_done"}, 32'(odone), 32'd0);
    chk({tag, "_error"}, 32'(oerror), 32'd0);
    chk({tag, "_code"}, 32'(oerr_code), 32'd0);
  endtask

  initial begin
    int k, rst_at, rst_cnt;
    irst       = 1'b1;
    istart     = 1'b0;
    cfg_echo   = 12'h1AA;
    cfg_ready  = 3;
    cfg_hcs    = 1'b1;
    cfg_silent = -1;
    n41        = 0;
    n55        = 0;
    repeat (3) @(negedge iclk);
    check_all_zero("reset");
    irst = 1'b0;

    // 1: full init, ready on third ACMD41
    start_run();
    wait_fin(2000);
    chk("t1_done", 32'(odone), 32'd1);
    chk("t1_rca", 32'(orca), 32'h0000_B368);
    chk("t1_hcs", 32'(ohcs), 32'd1);
    chk("t1_acmd41_count", 32'(n41), 32'd3);
    chk("t1_cmd55_count", 32'(n55), 32'd4);
    chk("t1_last_index", 32'(last_idx), 32'd6);
    chk("t1_last_arg", last_arg, 32'd2);

    // 2: CMD8 echo mismatch
    cfg_echo = 12'h0AA;
    start_run();
    wait_fin(2000);
    chk("t2_error", 32'(oerror), 32'd1);
    chk("t2_code", 32'(oerr_code), 32'd2);
    chk("t2_cmd55_count", 32'(n55), 32'd0);

    // 3: card never ready
    cfg_echo  = 12'h1AA;
    cfg_ready = 0;
    start_run();
    wait_fin(2000);
    chk("t3_acmd41_count", 32'(n41), 32'd4);
    chk("t3_code", 32'(oerr_code), 32'd3);

    // 4: card silent on CMD3
    cfg_ready  = 2;
    cfg_silent = 3;
    start_run();
    k = 0;
    while (!(ocmd_start && ocmd_index == 6'd3) && k < 2000) begin
      @(negedge iclk);
      k++;
    end
    chk("t4_cmd3_issued", 32'(ocmd_index), 32'd3);
    k       = 0;
    rst_at  = 0;
    rst_cnt = 0;
    while (!oerror && k < int'(TMO) + 10) begin
      @(negedge iclk);
      k++;
      if (odrv_rst) begin
        rst_cnt++;
        rst_at = k;
      end
    end
    chk("t4_timeout_delay", 32'(k), 32'(TMO));
    chk("t4_drv_rst_at", 32'(rst_at), 32'(TMO - 1));
    chk("t4_drv_rst_pulses", 32'(rst_cnt), 32'd1);
    chk("t4_code", 32'(oerr_code), 32'd1);
    cfg_silent = -1;

    // 5: reset in the middle of the ACMD41 loop
    cfg_ready = 0;
    start_run();
    k = 0;
    while (n41 < 2 && k < 2000) begin
      @(negedge iclk);
      k++;
    end
    chk("t5_in_loop", 32'(n41), 32'd2);
    irst   = 1'b1;
    istart = 1'b0;
    chk_en = 1'b0;
    @(negedge iclk);
    check_all_zero("t5_rst");
    irst = 1'b0;
    repeat (5) begin
      @(negedge iclk);
      chk("t5_idle_start", 32'(ocmd_start), 32'd0);
    end
    cfg_ready = 1;
    cfg_hcs   = 1'b0;
    start_run();
    k = 0;
    while (!ocmd_start && k < 200) begin
      @(negedge iclk);
      k++;
    end
    // One extra cycle registers the start edge before the power-up count begins.
    chk("t5_powerup_cycles", 32'(k), 32'(PWR + 1));
    wait_fin(2000);
    chk("t5_done", 32'(odone), 32'd1);

    // 6: start toggled while busy, then rerun after done
    cfg_ready = 2;
    start_run();
    repeat (10) @(negedge iclk);
    istart = 1'b0;
    repeat (3) @(negedge iclk);
    istart = 1'b1;
    repeat (40) @(negedge iclk);
    istart = 1'b0;
    repeat (2) @(negedge iclk);
    istart = 1'b1;
    wait_fin(2000);
    chk("t6_done", 32'(odone), 32'd1);
    chk("t6_hcs", 32'(ohcs), 32'd0);
    start_run();
    @(negedge iclk);
    chk("t6_done_cleared", 32'(odone), 32'd0);
    wait_fin(2000);
    chk("t6_rerun_done", 32'(odone), 32'd1);

    repeat (3) @(negedge iclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
